// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver state encoding, default
// baud divisor, data width and a 2-of-3 majority helper.
package uart_pkg;

   localparam int CLKS_PER_BIT_9600 = 5208;
   localparam int UART_DATA_W       = 8;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t START = 2'd1;
   localparam state_t DATA  = 2'd2;
   localparam state_t STOP  = 2'd3;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous input. Both stages reset
// to 1 so that an idle-high line reads as idle straight out of reset.
module bit_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state always uses non-blocking assignments; with
   // blocking ones the second stage would see this cycle's value and the
   // two flops would collapse into one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Build option: define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
   parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
   input  logic                   sysclk,
   input  logic                   rst_n,
   input  logic                   rx,
   output logic [UART_DATA_W-1:0] data,
   output logic                   valid,
   output logic                   frame_err,
   output logic                   busy
);

   localparam int           CNT_W   = 13;
   localparam int           IDX_W   = $clog2(UART_DATA_W);
   localparam [CNT_W-1:0]   HALF_C  = CNT_W'(HALF_BIT);
   localparam [CNT_W-1:0]   LAST_C  = CNT_W'(CLKS_PER_BIT - 1);
   localparam [IDX_W-1:0]   LAST_IX = IDX_W'(UART_DATA_W - 1);

   logic                   rx_s;
   logic                   sample;
   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       bit_idx;
   logic [UART_DATA_W-1:0] shreg;
   logic                   brk_lock;

   bit_sync u_sync (
      .clk   (sysclk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) hist <= 2'b11;
      else        hist <= {hist[0], rx_s};
   end

   assign sample = maj3(rx_s, hist[0], hist[1]);
`else
   assign sample = rx_s;
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         brk_lock  <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               // A line left low after a bad stop bit is a break, not a start.
               if (rx_s)           brk_lock <= 1'b0;
               else if (!brk_lock) state    <= START;
            end
            START: begin
               if (cnt == HALF_C) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= sample ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt == LAST_C) begin
                  cnt     <= '0;
                  shreg   <= {sample, shreg[UART_DATA_W-1:1]};
                  bit_idx <= bit_idx + IDX_W'(1);
                  if (bit_idx == LAST_IX) state <= STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt == LAST_C) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (sample) begin
                     data  <= shreg;
                     valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     brk_lock  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// scored against strobe times and bytes predicted from the frame format.
module tb_uart_rx;

   localparam int CPB    = 64;
   localparam int HALF   = (CPB - 1) / 2;
   localparam int STOP_E = HALF + 3 + 9 * CPB;
   localparam int FRAME  = 10 * CPB;

   logic       sysclk = 1'b0;
   logic       rst_n  = 1'b0;
   logic       rx     = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;

   int         obs_v_edge[$];
   logic [7:0] obs_v_data[$];
   int         obs_fe_edge[$];
   int         exp_v_edge[$];
   logic [7:0] exp_v_data[$];
   int         exp_fe_edge[$];
   logic [7:0] last_good = 8'h00;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_cnt);
      end
   endtask

   // Strobe monitor: records every valid / frame_err pulse with its edge number.
   always @(negedge sysclk) begin
      if (valid || frame_err) begin
         check("strobe_exclusive", {31'b0, valid & frame_err}, 32'd0);
         if (valid) begin
            obs_v_edge.push_back(edge_cnt);
            obs_v_data.push_back(data);
         end
         if (frame_err) obs_fe_edge.push_back(edge_cnt);
      end
   end

   task automatic wait_edge(input int target);
      while (edge_cnt < target) @(negedge sysclk);
   endtask

   // Called at a negedge; the next posedge is edge 0 of the frame.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int spike,
                             input bit track, input logic [7:0] exp_b);
      logic [9:0] bits;
      int         e0;
      bits = {stop, b, 1'b0};
      e0   = edge_cnt + 1;
      if (track) begin
         if (stop) begin
            exp_v_edge.push_back(e0 + STOP_E);
            exp_v_data.push_back(exp_b);
            last_good = exp_b;
         end else begin
            exp_fe_edge.push_back(e0 + STOP_E);
         end
      end
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < CPB; c++) begin
            rx = (spike >= 0 && i == spike + 1 && c == HALF + 1) ? 1'b1 : bits[i];
            @(negedge sysclk);
         end
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge sysclk);
   endtask

   task automatic score(input string tag);
      int nv;
      int nf;
      check({tag, "_valid_count"}, obs_v_edge.size(), exp_v_edge.size());
      check({tag, "_ferr_count"}, obs_fe_edge.size(), exp_fe_edge.size());
      nv = (obs_v_edge.size() < exp_v_edge.size()) ? obs_v_edge.size() : exp_v_edge.size();
      nf = (obs_fe_edge.size() < exp_fe_edge.size()) ? obs_fe_edge.size() : exp_fe_edge.size();
      for (int i = 0; i < nv; i++) begin
         check({tag, "_valid_edge"}, obs_v_edge[i], exp_v_edge[i]);
         check({tag, "_valid_data"}, {24'b0, obs_v_data[i]}, {24'b0, exp_v_data[i]});
      end
      for (int i = 0; i < nf; i++)
         check({tag, "_ferr_edge"}, obs_fe_edge[i], exp_fe_edge[i]);
      check({tag, "_data_hold"}, {24'b0, data}, {24'b0, last_good});
      obs_v_edge.delete();
      obs_v_data.delete();
      obs_fe_edge.delete();
      exp_v_edge.delete();
      exp_v_data.delete();
      exp_fe_edge.delete();
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog expired at edge %0d", edge_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int         e0;
      logic [7:0] spike_exp;
      logic [7:0] b;
      logic       stop;
      int         gap;

      // Reset state.
      repeat (5) @(negedge sysclk);
      check("rst_data", {24'b0, data}, 32'h00);
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_ferr", {31'b0, frame_err}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      idle(3);

      // Frame 0xA5 with exact edge timing of busy and valid.
      e0 = edge_cnt + 1;
      fork
         send_frame(8'hA5, 1'b1, -1, 1'b1, 8'hA5);
         begin
            wait_edge(e0 + 1);
            check("a5_busy_e1", {31'b0, busy}, 32'd0);
            wait_edge(e0 + 2);
            check("a5_busy_e2", {31'b0, busy}, 32'd1);
            wait_edge(e0 + STOP_E - 1);
            check("a5_busy_prestop", {31'b0, busy}, 32'd1);
            check("a5_valid_prestop", {31'b0, valid}, 32'd0);
            wait_edge(e0 + STOP_E);
            check("a5_busy_stop", {31'b0, busy}, 32'd0);
            check("a5_valid_stop", {31'b0, valid}, 32'd1);
            check("a5_data_stop", {24'b0, data}, 32'hA5);
            wait_edge(e0 + STOP_E + 1);
            check("a5_valid_width", {31'b0, valid}, 32'd0);
         end
      join
      idle(CPB);
      score("a5");

      // Short low glitch on an idle line is rejected at the start re-check.
      e0 = edge_cnt + 1;
      rx = 1'b0;
      repeat (20) @(negedge sysclk);
      rx = 1'b1;
      wait_edge(e0 + HALF + 2);
      check("glitch_busy_before", {31'b0, busy}, 32'd1);
      wait_edge(e0 + HALF + 3);
      check("glitch_busy_after", {31'b0, busy}, 32'd0);
      idle(2 * CPB);
      score("glitch");

      // Bad stop bit followed by a held-low break: one frame_err only.
      send_frame(8'h3C, 1'b0, -1, 1'b1, 8'h00);
      rx = 1'b0;
      repeat (12 * CPB) @(negedge sysclk);
      idle(2 * CPB);
      score("ferr_break");

      // Back-to-back frames with no idle gap.
      send_frame(8'h00, 1'b1, -1, 1'b1, 8'h00);
      send_frame(8'hFF, 1'b1, -1, 1'b1, 8'hFF);
      idle(CPB);
      score("b2b");

      // Reset during data bit 4 aborts the frame silently.
      e0 = edge_cnt + 1;
      fork
         send_frame(8'hF5, 1'b1, -1, 1'b0, 8'h00);
         begin
            wait_edge(e0 + 5 * CPB + CPB / 2);
            rst_n = 1'b0;
            @(negedge sysclk);
            check("midrst_busy", {31'b0, busy}, 32'd0);
            check("midrst_data", {24'b0, data}, 32'h00);
            repeat (2) @(negedge sysclk);
            rst_n = 1'b1;
         end
      join
      last_good = 8'h00;
      idle(2 * CPB);
      score("abort");
      send_frame(8'h81, 1'b1, -1, 1'b1, 8'h81);
      idle(CPB);
      score("after_rst");

      // One-cycle high spike exactly at the data bit 2 sample.
`ifdef UART_RX_MAJORITY_EN
      spike_exp = 8'h00;
`else
      spike_exp = 8'h04;
`endif
      send_frame(8'h00, 1'b1, 2, 1'b1, spike_exp);
      idle(CPB);
      score("spike");

      // Random frames, random gaps (including none), occasional bad stop bit.
      for (int n = 0; n < 24; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         gap  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 2 * CPB);
         if (!stop && gap == 0) gap = 1;
         send_frame(b, stop, -1, 1'b1, b);
         idle(gap);
      end
      idle(FRAME);
      score("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
